// File: rtl/bcd_countdown_99.sv
// Two-digit BCD down-counter with a prescaled step, run/pause level control,
// synchronous preset load (digits clamped to 9) and a one-cycle done pulse at 00.
module bcd_countdown_99 #(
    parameter int TICK_DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_high,
    input  logic [3:0] load_low,
    input  logic       start_pause,
    output logic [3:0] count_high,
    output logic [3:0] count_low,
    output logic       running,
    output logic       zero,
    output logic       done
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [3:0]    high_q, low_q;
    logic [PW-1:0] presc_q;
    logic          running_q, done_q;

    logic [3:0]    high_d, low_d;
    logic [3:0]    load_high_c, load_low_c;
    logic          dec_to_zero;

    assign load_high_c = (load_high > 4'd9) ? 4'd9 : load_high;
    assign load_low_c  = (load_low  > 4'd9) ? 4'd9 : load_low;

    // Decremented count, with a units-digit borrow; saturates at 00.
    always_comb begin
        high_d = high_q;
        low_d  = low_q;
        if (low_q != 4'd0) begin
            low_d = low_q - 4'd1;
        end else if (high_q != 4'd0) begin
            low_d  = 4'd9;
            high_d = high_q - 4'd1;
        end
        dec_to_zero = (high_d == 4'd0) && (low_d == 4'd0);
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            high_q    <= 4'd9;
            low_q     <= 4'd9;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                high_q    <= load_high_c;
                low_q     <= load_low_c;
                presc_q   <= '0;
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_pause && !zero) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                            presc_q   <= '0;
                        end
                    end
                    RUN: begin
                        if (!start_pause) begin
                            // Pausing discards any partial tick.
                            state_q   <= IDLE;
                            running_q <= 1'b0;
                            presc_q   <= '0;
                        end else if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            high_q  <= high_d;
                            low_q   <= low_d;
                            if (dec_to_zero) begin
                                state_q   <= DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count_high = high_q;
    assign count_low  = low_q;
    assign running    = running_q;
    assign done       = done_q;
    assign zero       = (high_q == 4'd0) && (low_q == 4'd0);

endmodule

// File: tb/tb_bcd_countdown_99.sv
// Directed bench for bcd_countdown_99: one instance with TICK_DIV=1 and one
// with TICK_DIV=4, sharing clock and reset, each with its own control inputs.
module tb_bcd_countdown_99;

    logic       clock = 1'b0;
    logic       reset;
    logic       ld1, sp1, ld4, sp4;
    logic [3:0] lh1, ll1, lh4, ll4;
    logic [3:0] ch1, cl1, ch4, cl4;
    logic       run1, z1, dn1, run4, z4, dn4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    bcd_countdown_99 #(.TICK_DIV(1)) dut1 (
        .clock(clock), .reset(reset), .load(ld1), .load_high(lh1), .load_low(ll1),
        .start_pause(sp1), .count_high(ch1), .count_low(cl1),
        .running(run1), .zero(z1), .done(dn1)
    );

    bcd_countdown_99 #(.TICK_DIV(4)) dut4 (
        .clock(clock), .reset(reset), .load(ld4), .load_high(lh4), .load_low(ll4),
        .start_pause(sp4), .count_high(ch4), .count_low(cl4),
        .running(run4), .zero(z4), .done(dn4)
    );

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ld1 = 1'b0; sp1 = 1'b0; lh1 = 4'd0; ll1 = 4'd0;
        ld4 = 1'b0; sp4 = 1'b0; lh4 = 4'd0; ll4 = 4'd0;
        #12;
        chk("reset_count1", {ch1, cl1}, 8'h99);
        chk("reset_run1",   run1, 1'b0);
        chk("reset_zero1",  z1,   1'b0);
        chk("reset_done1",  dn1,  1'b0);
        chk("reset_count4", {ch4, cl4}, 8'h99);
        @(negedge clock);
        reset = 1'b0;

        // Full countdown 99 -> 00 with TICK_DIV=1.
        sp1 = 1'b1;
        tick();
        chk("enter_run", run1, 1'b1);
        chk("enter_cnt", {ch1, cl1}, 8'h99);
        for (int i = 1; i <= 99; i++) begin
            tick();
            chk("full_cnt",  {ch1, cl1}, bcd(99 - i));
            chk("full_done", dn1, (i == 99) ? 1'b1 : 1'b0);
            chk("full_run",  run1, (i == 99) ? 1'b0 : 1'b1);
        end
        chk("full_zero", z1, 1'b1);

        // DONE holds 00 regardless of start_pause.
        tick();
        chk("done_pulse_end", dn1, 1'b0);
        chk("done_hold",      {ch1, cl1}, 8'h00);
        sp1 = 1'b0;
        tick();
        chk("done_hold_sp0",  {ch1, cl1}, 8'h00);
        sp1 = 1'b1;
        tick();
        chk("done_hold_sp1",  {ch1, cl1}, 8'h00);
        chk("done_not_run",   run1, 1'b0);

        // Load 2/5 from DONE with start_pause high.
        ld1 = 1'b1; lh1 = 4'd2; ll1 = 4'd5;
        tick();
        chk("ld25_cnt",  {ch1, cl1}, 8'h25);
        chk("ld25_idle", run1, 1'b0);
        ld1 = 1'b0;
        tick();
        chk("ld25_run",  run1, 1'b1);
        chk("ld25_cnt2", {ch1, cl1}, 8'h25);
        tick();
        chk("ld25_dec",  {ch1, cl1}, 8'h24);

        // Borrow from 10 down to 00.
        ld1 = 1'b1; lh1 = 4'd1; ll1 = 4'd0;
        tick();
        chk("ld10_cnt",  {ch1, cl1}, 8'h10);
        chk("ld10_idle", run1, 1'b0);
        ld1 = 1'b0;
        tick();
        chk("ld10_run",  run1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("borrow_cnt",  {ch1, cl1}, bcd(10 - i));
            chk("borrow_done", dn1, (i == 10) ? 1'b1 : 1'b0);
        end

        // Zero preset: no done, stays IDLE with start_pause high.
        ld1 = 1'b1; lh1 = 4'd0; ll1 = 4'd0;
        tick();
        chk("ld00_zero", z1, 1'b1);
        chk("ld00_done", dn1, 1'b0);
        chk("ld00_run",  run1, 1'b0);
        ld1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld00_stay_run",  run1, 1'b0);
            chk("ld00_stay_done", dn1, 1'b0);
            chk("ld00_stay_cnt",  {ch1, cl1}, 8'h00);
        end

        // Clamped load mid-run overrides the decrement.
        ld1 = 1'b1; lh1 = 4'd5; ll1 = 4'd0;
        tick();
        ld1 = 1'b0;
        tick();
        tick();
        chk("pre_clamp_cnt", {ch1, cl1}, 8'h49);
        ld1 = 1'b1; lh1 = 4'hC; ll1 = 4'd3;
        tick();
        chk("clamp_cnt",  {ch1, cl1}, 8'h93);
        chk("clamp_idle", run1, 1'b0);
        ld1 = 1'b0;
        tick();
        chk("clamp_run",  run1, 1'b1);
        chk("clamp_cnt2", {ch1, cl1}, 8'h93);
        tick();
        chk("clamp_dec",  {ch1, cl1}, 8'h92);

        // Asynchronous reset between edges at count 47.
        ld1 = 1'b1; lh1 = 4'd4; ll1 = 4'd8;
        tick();
        ld1 = 1'b0;
        tick();
        tick();
        chk("pre_rst_cnt", {ch1, cl1}, 8'h47);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_cnt",  {ch1, cl1}, 8'h99);
        chk("arst_run",  run1, 1'b0);
        chk("arst_done", dn1, 1'b0);
        chk("arst_zero", z1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("post_rst_run", run1, 1'b1);
        chk("post_rst_cnt", {ch1, cl1}, 8'h99);
        tick();
        chk("post_rst_dec", {ch1, cl1}, 8'h98);

        // Pause with TICK_DIV=4: run to 95.
        sp4 = 1'b1;
        tick();
        chk("p4_enter", run4, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("p4_cnt", {ch4, cl4}, bcd(99 - i / 4));
        end
        sp4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("p4_pause_cnt", {ch4, cl4}, 8'h95);
            chk("p4_pause_run", run4, 1'b0);
        end
        sp4 = 1'b1;
        tick();
        chk("p4_resume", run4, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("p4_resume_cnt", {ch4, cl4}, (i == 4) ? 8'h94 : 8'h95);
        end

        // Toggling start_pause every cycle never reaches a tick.
        for (int i = 0; i < 12; i++) begin
            sp4 = ~sp4;
            tick();
            chk("p4_toggle_cnt", {ch4, cl4}, 8'h94);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
